// File: rtl/libsv_arbiters_pkg.sv
// libsv_arbiters_pkg: shared types for the arbiter blocks
package libsv_arbiters_pkg;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_e;
endpackage

// File: rtl/onehot_to_bin.sv
// onehot_to_bin: binary index of the set bit of a one-hot (or zero) vector
module onehot_to_bin #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_onehot,
  output logic [IW-1:0] o_bin
);
  always_comb begin
    o_bin = '0;
    for (int i = 0; i < N; i++)
      if (i_onehot[i]) o_bin = o_bin | IW'(i);
  end
endmodule

// File: rtl/round_robin_arbiter.sv
// round_robin_arbiter: registered one-hot round-robin grant with valid/ready handshake
module round_robin_arbiter
  import libsv_arbiters_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          aresetn,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          out_valid,
  input  logic          out_ready
);
  arb_state_e     r_state;
  logic [IW-1:0]  r_ptr;
  logic [N-1:0]   r_gnt;
  logic [IW-1:0]  r_gnt_idx;
  logic           r_out_valid;
  logic           w_xfer;
  logic           w_arb;
  logic [IW-1:0]  w_ptr_inc;
  logic [IW-1:0]  w_base;
  logic [IW-1:0]  w_j;
  logic [N-1:0]   w_pick;
  logic [N-1:0]   w_gnt_nxt;
  logic [IW-1:0]  w_idx_nxt;
  arb_state_e     w_state_nxt;
  assign w_xfer      = r_out_valid && out_ready;
  assign w_arb       = (r_state == IDLE) || w_xfer;
  assign w_ptr_inc   = (r_gnt_idx == IW'(N - 1)) ? '0 : r_gnt_idx + 1'b1;
  // a transfer re-arbitrates in the same edge, so scan from the updated pointer
  assign w_base      = w_xfer ? w_ptr_inc : r_ptr;
  assign w_gnt_nxt   = w_arb ? w_pick : r_gnt;
  assign w_state_nxt = w_arb ? ((|req) ? BUSY : IDLE) : r_state;
  always_comb begin
    w_pick = '0;
    w_j    = '0;
    for (int i = 0; i < N; i++) begin
      w_j = IW'((int'(w_base) + i) % N);
      if (w_pick == '0 && req[w_j]) w_pick[w_j] = 1'b1;
    end
  end
  onehot_to_bin #(.N(N)) u_idx (
    .i_onehot (w_gnt_nxt),
    .o_bin    (w_idx_nxt)
  );
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_gnt_idx   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_idx   <= w_idx_nxt;
      r_out_valid <= |w_gnt_nxt;
      if (w_xfer) r_ptr <= w_ptr_inc;
    end
  end
  assign gnt       = r_gnt;
  assign gnt_idx   = r_gnt_idx;
  assign out_valid = r_out_valid;
endmodule

// File: tb/tb_round_robin_arbiter.sv
// tb_round_robin_arbiter: directed scenarios plus a constrained-random invariant run
module tb_round_robin_arbiter;
  localparam int N  = 4;
  localparam int IW = $clog2(N);
  logic          clk;
  logic          aresetn;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_idx;
  logic          out_valid;
  logic          out_ready;
  int errors;
  int checks;

  round_robin_arbiter #(.N(N)) dut (
    .clk       (clk),
    .aresetn   (aresetn),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    aresetn   = 1'b0;
    req       = '0;
    out_ready = 1'b0;
    step();
    step();
    aresetn = 1'b1;
  endtask

  task automatic test_reset();
    aresetn   = 1'b0;
    req       = 4'b1111;
    out_ready = 1'b1;
    step();
    step();
    checks++;
    if ({gnt, gnt_idx, out_valid} !== 7'b0) begin
      errors++;
      $display("FAIL reset: gnt=%b idx=%0d valid=%b expected 0000/0/0", gnt, gnt_idx, out_valid);
    end
    req = '0;
    aresetn = 1'b1;
    step();
    checks++;
    if ({gnt, out_valid} !== 5'b0) begin
      errors++;
      $display("FAIL idle_no_req: gnt=%b valid=%b expected 0000/0", gnt, out_valid);
    end
  endtask

  task automatic test_single();
    req = 4'b0001;
    out_ready = 1'b1;
    step();
    checks++;
    if ({gnt, gnt_idx, out_valid} !== {4'b0001, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL single_grant: gnt=%b idx=%0d valid=%b expected 0001/0/1", gnt, gnt_idx, out_valid);
    end
    req = '0;
    step();
    checks++;
    if ({gnt, gnt_idx, out_valid} !== 7'b0) begin
      errors++;
      $display("FAIL single_release: gnt=%b idx=%0d valid=%b expected 0000/0/0", gnt, gnt_idx, out_valid);
    end
    step();
    checks++;
    if ({gnt, out_valid} !== 5'b0) begin
      errors++;
      $display("FAIL single_idle: gnt=%b valid=%b expected 0000/0", gnt, out_valid);
    end
  endtask

  task automatic test_rotation();
    logic [N-1:0] exp_seq [5];
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    req = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (gnt !== exp_seq[i] || gnt_idx !== IW'(i % N) || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL rotation[%0d]: gnt=%b idx=%0d valid=%b expected %b/%0d/1", i, gnt, gnt_idx, out_valid, exp_seq[i], i % N);
      end
    end
    req = '0;
    step();
  endtask

  task automatic test_backpressure();
    do_reset();
    req = 4'b0110;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({gnt, gnt_idx, out_valid} !== {4'b0010, 2'd1, 1'b1}) begin
        errors++;
        $display("FAIL stall[%0d]: gnt=%b idx=%0d valid=%b expected 0010/1/1", i, gnt, gnt_idx, out_valid);
      end
    end
    req = 4'b0100;
    step();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL stall_req_change: gnt=%b expected 0010", gnt);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if ({gnt, gnt_idx, out_valid} !== {4'b0100, 2'd2, 1'b1}) begin
      errors++;
      $display("FAIL stall_release: gnt=%b idx=%0d valid=%b expected 0100/2/1", gnt, gnt_idx, out_valid);
    end
    req = '0;
    step();
    checks++;
    if ({gnt, out_valid} !== 5'b0) begin
      errors++;
      $display("FAIL stall_drain: gnt=%b valid=%b expected 0000/0", gnt, out_valid);
    end
  endtask

  task automatic test_wrap();
    req = 4'b1000;
    out_ready = 1'b1;
    step();
    checks++;
    if ({gnt, gnt_idx} !== {4'b1000, 2'd3}) begin
      errors++;
      $display("FAIL wrap_first: gnt=%b idx=%0d expected 1000/3", gnt, gnt_idx);
    end
    step();
    checks++;
    if ({gnt, gnt_idx, out_valid} !== {4'b1000, 2'd3, 1'b1}) begin
      errors++;
      $display("FAIL wrap_lone: gnt=%b idx=%0d valid=%b expected 1000/3/1", gnt, gnt_idx, out_valid);
    end
    req = 4'b1001;
    step();
    checks++;
    if ({gnt, gnt_idx} !== {4'b0001, 2'd0}) begin
      errors++;
      $display("FAIL wrap_to_zero: gnt=%b idx=%0d expected 0001/0", gnt, gnt_idx);
    end
    req = '0;
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0100;
    out_ready = 1'b0;
    step();
    checks++;
    if ({gnt, gnt_idx, out_valid} !== {4'b0100, 2'd2, 1'b1}) begin
      errors++;
      $display("FAIL midrst_setup: gnt=%b idx=%0d valid=%b expected 0100/2/1", gnt, gnt_idx, out_valid);
    end
    #3;
    aresetn = 1'b0;
    #1;
    checks++;
    if ({gnt, gnt_idx, out_valid} !== 7'b0) begin
      errors++;
      $display("FAIL midrst_async: gnt=%b idx=%0d valid=%b expected 0000/0/0", gnt, gnt_idx, out_valid);
    end
    req = 4'b1111;
    out_ready = 1'b1;
    step();
    aresetn = 1'b1;
    step();
    checks++;
    if ({gnt, gnt_idx, out_valid} !== {4'b0001, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL midrst_resume: gnt=%b idx=%0d valid=%b expected 0001/0/1", gnt, gnt_idx, out_valid);
    end
    req = '0;
    step();
  endtask

  task automatic test_random();
    logic [N-1:0]  pg, preq, served;
    logic [IW-1:0] eidx;
    logic          px, pstall;
    int            wait_cnt [N];
    do_reset();
    for (int k = 0; k < N; k++) wait_cnt[k] = 0;
    for (int c = 0; c < 10000; c++) begin
      pg     = gnt;
      preq   = req;
      px     = out_valid && out_ready;
      pstall = out_valid && !out_ready;
      step();
      checks++;
      if (!$onehot0(gnt)) begin
        errors++;
        $display("FAIL rnd_onehot cyc %0d: gnt=%b expected zero or one-hot", c, gnt);
      end
      checks++;
      if (out_valid !== (|gnt)) begin
        errors++;
        $display("FAIL rnd_valid cyc %0d: valid=%b expected %b", c, out_valid, |gnt);
      end
      eidx = '0;
      for (int k = 0; k < N; k++) if (gnt[k]) eidx = IW'(k);
      checks++;
      if (gnt_idx !== eidx) begin
        errors++;
        $display("FAIL rnd_idx cyc %0d: idx=%0d expected %0d", c, gnt_idx, eidx);
      end
      if (pstall) begin
        checks++;
        if (gnt !== pg) begin
          errors++;
          $display("FAIL rnd_stable cyc %0d: gnt=%b expected %b", c, gnt, pg);
        end
      end
      served = px ? pg : '0;
      for (int k = 0; k < N; k++) begin
        if (!preq[k] || served[k]) wait_cnt[k] = 0;
        else if (px) wait_cnt[k]++;
        checks++;
        if (wait_cnt[k] > N) begin
          errors++;
          $display("FAIL rnd_starve cyc %0d: req %0d waited %0d transfers, limit %0d", c, k, wait_cnt[k], N);
        end
      end
      req       = (req & ~served) | (N'($urandom) & N'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
    end
    req = '0;
    out_ready = 1'b1;
    step();
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    aresetn   = 1'b0;
    req       = '0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/round_robin_arbiter.md
ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

Interface
REQ-001 SHALL have parameter N, default 4: number of requesters; legal range 2..32.
REQ-002 SHALL have local parameter IW = $clog2(N): width of the grant index.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port aresetn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req  input  N  per-requester request; req[k] held high until granted and accepted.
REQ-006 SHALL have port gnt  output  N  registered one-hot grant, drives the sel input of the downstream one-hot mux.
REQ-007 SHALL have port gnt_idx  output  IW  binary index of the set gnt bit; 0 when gnt is 0.
REQ-008 SHALL have port out_valid  output  1  high when gnt is non-zero, so the muxed data is valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the muxed data this cycle.

Function
REQ-010 SHALL implement a two-state FSM, IDLE and BUSY.
REQ-011 SHALL define transfer as out_valid && out_ready at a rising clk edge.
REQ-012 In IDLE with req == 0, SHALL hold gnt = 0 and out_valid = 0.
REQ-013 In IDLE with req != 0, SHALL register the winner and enter BUSY, so gnt is visible one cycle after req rises.
REQ-014 SHALL pick the winner as the first set req bit scanning upward from ptr, wrapping from N-1 to 0.
REQ-015 SHALL reset ptr to 0, and after each transfer set ptr to (granted index + 1) mod N.
REQ-016 In BUSY, SHALL keep gnt, gnt_idx and out_valid = 1 constant until a transfer occurs.
  - This holds even if the granted req deasserts; that is a requester protocol violation.
REQ-017 On a transfer with req != 0, SHALL register a new winner using the updated ptr and stay in BUSY.
  - Gives back-to-back grants at full throughput.
  - The just-served requester has the lowest priority but may win again if it is the only one requesting.
REQ-018 On a transfer with req == 0, SHALL clear gnt and return to IDLE.
REQ-019 SHALL ignore req changes in BUSY except when a transfer occurs.
REQ-020 SHALL guarantee that gnt is always zero or exactly one-hot.
REQ-021 SHALL guarantee that out_valid == |gnt in every cycle.
REQ-022 SHALL guarantee that gnt_idx == the position of the set gnt bit.
REQ-023 SHALL guarantee starvation freedom: a continuously asserted req is granted within N transfers.
REQ-024 SHALL compute everything combinationally from registered state and inputs, with all outputs registered except none; gnt, gnt_idx and out_valid are flop outputs.

Reset
REQ-025 On aresetn low, SHALL asynchronously set state = IDLE, ptr = 0, gnt = 0, gnt_idx = 0, out_valid = 0.
REQ-026 On reset mid-transfer (BUSY), SHALL drop the pending grant with no transfer and no ptr update.
REQ-027 SHALL resume arbitration on the first rising clk edge after aresetn deasserts.

Structure
REQ-028 SHALL place the FSM state enum (IDLE, BUSY) in the shared package libsv_arbiters_pkg.
REQ-029 SHALL use one sub-module, onehot_to_bin, parameterised by N, to derive gnt_idx from the next-state grant vector.
REQ-030 SHALL use no other sub-modules; the rotate-and-priority-select logic is written inline.

Verification (N=4)
REQ-031 Reset and single request: hold aresetn=0 and check all outputs are 0; release aresetn; raise req=0001 with out_ready=1 -> next cycle gnt=0001, gnt_idx=0, out_valid=1; after the transfer with req=0, gnt=0 and the FSM is in IDLE.
REQ-032 Rotation: hold req=1111 with out_ready=1 -> gnt sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles.
REQ-033 Backpressure: req=0110 with out_ready=0 for 5 cycles -> gnt=0010 stable; change req to 0100 mid-stall -> gnt still 0010; raise out_ready -> next gnt=0100.
REQ-034 Wrap and lone requester: after serving idx 3, req=1000 only -> gnt=1000 again; after serving idx 3, req=1001 -> gnt=0001.
REQ-035 Reset mid-operation: assert aresetn low asynchronously while gnt=0100 and out_ready=0 -> gnt=0 immediately; after release with req=1111 -> gnt=0001 (ptr reset to 0).
REQ-036 Randomised run: random req/out_ready for 10k cycles -> assertions on one-hot gnt, out_valid==|gnt, gnt_idx consistency, grant stability under backpressure, and a starvation bound of N transfers all hold.
